// File: rtl/vertex_accum_buffer.sv
// Accumulates CHUNKS partial dot-products per node in a tagged slot table; completed sums queue in a small FIFO.
// Latency: a node sum appears on out_* the cycle after its final partial is accepted (no same-cycle bypass).
// Backpressure: in_ready drops on a slot collision or when a completing partial finds the FIFO full and not popping.
module vertex_accum_buffer #(
    parameter int FV_SIZE    = 16,
    parameter int NODE_ID_W  = 6,
    parameter int CHUNKS     = 4,
    parameter int SLOTS      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FV_SIZE-1:0]   in_data,
    input  logic [NODE_ID_W-1:0] in_node_id,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FV_SIZE-1:0]   out_data,
    output logic [NODE_ID_W-1:0] out_node_id,
    output logic                 busy
);

    localparam int CW = $clog2(CHUNKS + 1);
    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = NODE_ID_W + FV_SIZE;

    // Slot table
    logic [SLOTS-1:0]     valid_q, valid_d;
    logic [NODE_ID_W-1:0] tag_q [SLOTS];
    logic [NODE_ID_W-1:0] tag_d [SLOTS];
    logic [CW-1:0]        cnt_q [SLOTS];
    logic [CW-1:0]        cnt_d [SLOTS];
    logic [FV_SIZE-1:0]   sum_q [SLOTS];
    logic [FV_SIZE-1:0]   sum_d [SLOTS];

    // Result FIFO, entries packed as {node_id, sum}
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        mem_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]        count_q, count_d;

    logic [IW-1:0]        idx;
    logic                 hit;
    logic                 free;
    logic                 fin;
    logic                 fifo_full;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [CW-1:0]        cnt_next;
    logic [FV_SIZE-1:0]   acc_sum;
    logic [PW-1:0]        head_ptr;

    // Slot lookup for the presented partial and the resulting handshake decision
    always_comb begin
        idx = '0;
        if (SLOTS > 1) begin
            idx = in_node_id[IW-1:0];
        end
        hit       = valid_q[idx] && (tag_q[idx] == in_node_id);
        free      = !valid_q[idx];
        cnt_next  = hit ? (cnt_q[idx] + CW'(1)) : CW'(1);
        fin       = (cnt_next == CW'(CHUNKS));
        acc_sum   = (hit ? sum_q[idx] : '0) + in_data;
        fifo_full = (count_q == NW'(FIFO_DEPTH));
        out_valid = (count_q != '0);
        pop       = out_valid && out_ready;
        // A completing partial may enter a full FIFO only when the head leaves in the same cycle.
        in_ready  = reset && (free || hit) && !(fin && fifo_full && !pop);
        accept    = in_valid && in_ready;
        push      = accept && fin;
    end

    // Slot table update: open, extend, or retire the slot addressed by the accepted partial
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        if (accept) begin
            if (fin) begin
                valid_d[idx] = 1'b0;
                cnt_d[idx]   = '0;
            end else begin
                valid_d[idx] = 1'b1;
                tag_d[idx]   = in_node_id;
                cnt_d[idx]   = cnt_next;
                sum_d[idx]   = acc_sum;
            end
        end
    end

    // FIFO pointers, occupancy and storage; simultaneous push and pop leave the count unchanged
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_node_id, acc_sum};
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
    end

    // Head presentation; when empty, point at the most recently popped entry so out_* hold the last head
    always_comb begin
        head_ptr = rd_ptr_q;
        if (count_q == '0) begin
            head_ptr = (rd_ptr_q == '0) ? PW'(FIFO_DEPTH - 1) : rd_ptr_q - PW'(1);
        end
        {out_node_id, out_data} = mem_q[head_ptr];
        busy = (|valid_q) || (count_q != '0);
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag_q[i] <= '0;
                cnt_q[i] <= '0;
                sum_q[i] <= '0;
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_vertex_accum_buffer.sv
// Testbench for vertex_accum_buffer: scenario tasks plus a scoreboard checked on every output handshake.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
// Every wait on the DUT is bounded and a timeout counts as a failure.
module tb_vertex_accum_buffer;

    localparam int CHUNKS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [5:0]  in_node_id;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [5:0]  out_node_id;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [5:0]  id;
        logic [15:0] d;
    } res_t;

    res_t        sb[$];
    logic [15:0] m_sum [64];
    int          m_cnt [64];

    always #5 clk = ~clk;

    vertex_accum_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_node_id  (in_node_id),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_node_id (out_node_id),
        .busy        (busy)
    );

    // Scoreboard: each output handshake must match the oldest expected completion
    always @(negedge clk) begin
        res_t exp_r;
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got id=%0d data=%h, expected no output", out_node_id, out_data);
            end else begin
                exp_r = sb.pop_front();
                if (out_node_id !== exp_r.id || out_data !== exp_r.d) begin
                    errors++;
                    $display("FAIL sb_result: got id=%0d data=%h, expected id=%0d data=%h",
                             out_node_id, out_data, exp_r.id, exp_r.d);
                end
            end
        end
    end

    // Reference accumulation per node id, independent of slot mapping
    task automatic model_accept(input logic [5:0] id, input logic [15:0] d);
        if (m_cnt[id] == 0) m_sum[id] = d;
        else m_sum[id] = m_sum[id] + d;
        m_cnt[id]++;
        if (m_cnt[id] == CHUNKS) begin
            sb.push_back('{id: id, d: m_sum[id]});
            m_cnt[id] = 0;
        end
    endtask

    // Present one partial and hold it until accepted; returns 1 unit after the accepting posedge
    task automatic send(input logic [5:0] id, input logic [15:0] d);
        int t;
        in_valid   = 1'b1;
        in_node_id = id;
        in_data    = d;
        t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: node %0d in_ready=%b, expected 1", id, in_ready);
        end else begin
            model_accept(id, d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset      = 1'b0;
        in_valid   = 1'b1;
        in_node_id = 6'd0;
        in_data    = 16'd7;
        out_ready  = 1'b1;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        end
        checks++;
        if (out_data !== 16'd0 || out_node_id !== 6'd0) begin
            errors++;
            $display("FAIL rst_out_data: got id=%0d data=%h, expected 0/0", out_node_id, out_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b, expected 1", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_single_node;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(6'd5, 16'd10);
        send(6'd5, 16'd20);
        send(6'd5, 16'd30);
        send(6'd5, 16'd40);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL n5_latency: out_valid=%b, expected 1", out_valid); end
        checks++;
        if (out_node_id !== 6'd5 || out_data !== 16'd100) begin
            errors++;
            $display("FAIL n5_value: got id=%0d data=%0d, expected id=5 data=100", out_node_id, out_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL n5_hold: out_valid=%b busy=%b, expected 1/1", out_valid, busy);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL n5_popped: out_valid=%b busy=%b, expected 0/0", out_valid, busy);
        end
    endtask

    task automatic test_interleave;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(6'd1, 16'd1);
            send(6'd2, 16'd2);
        end
    endtask

    task automatic test_collision;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(6'd1, 16'd3);
        send(6'd1, 16'd4);
        in_valid   = 1'b1;
        in_node_id = 6'd5;
        in_data    = 16'd9;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL coll_blocked: in_ready=%b, expected 0", in_ready); end
        end
        @(posedge clk);
        #1;
        send(6'd1, 16'd5);
        send(6'd1, 16'd6);
        in_valid   = 1'b1;
        in_node_id = 6'd5;
        in_data    = 16'd9;
        #2;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL coll_release: in_ready=%b, expected 1", in_ready); end
        send(6'd5, 16'd9);
        send(6'd5, 16'd1);
        send(6'd5, 16'd1);
        send(6'd5, 16'd1);
    endtask

    task automatic test_wrap;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(6'd3, 16'hFFFF);
        send(6'd3, 16'h0002);
        send(6'd3, 16'h0000);
        send(6'd3, 16'h0000);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_sum: out_valid=%b data=%h, expected 1/0001", out_valid, out_data);
        end
    endtask

    task automatic test_fifo_full;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int n = 16; n < 20; n++) begin
            for (int c = 0; c < CHUNKS; c++) send(6'(n), 16'(n));
        end
        send(6'd20, 16'd1);
        send(6'd20, 16'd2);
        send(6'd20, 16'd3);
        in_valid   = 1'b1;
        in_node_id = 6'd20;
        in_data    = 16'd4;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_blocked: in_ready=%b, expected 0", in_ready); end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pushpop: in_ready=%b, expected 1", in_ready); end
        if (in_ready === 1'b1) model_accept(6'd20, 16'd4);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        // Four entries should remain: a completing partial must be refused again
        send(6'd21, 16'd1);
        send(6'd21, 16'd1);
        send(6'd21, 16'd1);
        in_valid   = 1'b1;
        in_node_id = 6'd21;
        in_data    = 16'd1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_count_kept: in_ready=%b, expected 0", in_ready); end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(6'd21, 16'd1);
    endtask

    task automatic test_drain;
        int t;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        t = 0;
        while ((sb.size() != 0 || out_valid === 1'b1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_sb: %0d results outstanding, expected 0", sb.size()); end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: out_valid=%b busy=%b, expected 0/0", out_valid, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            m_sum[i] = '0;
            m_cnt[i] = 0;
        end
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_node_id = '0;
        in_data    = '0;
        out_ready  = 1'b0;
        test_reset();
        test_single_node();
        test_interleave();
        test_collision();
        test_wrap();
        test_fifo_full();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
